// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state, default widths and a one-hot to index helper.
//   Used by mem_burst_arbiter and rr_pick.
package mem_burst_pkg;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 24;
    localparam int DEF_LEN_W  = 10;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

    // Supports up to 8 channels, the widest configuration allowed.
    function automatic logic [2:0] oh_idx(input logic [7:0] oh);
        oh_idx = '0;
        for (int i = 0; i < 8; i++) if (oh[i]) oh_idx = 3'(i);
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational masked priority picker.
//   req    : per-channel requests
//   rr_ptr : channel with highest priority this round
//   win    : one-hot first requester at or after rr_ptr (modulo N), zero if none
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  win
);
    logic [PW-1:0] j;
    // Scan downward so the last hit kept is the one closest to rr_ptr.
    always_comb begin
        win = '0;
        j   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(rr_ptr) + i) % N);
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: round-robin arbiter of NUM_CH write-burst channels onto one memory burst controller.
//   mem_clk, rst_n (sync, active-low)
//   ch_wr_burst_req/len/addr/data     : per-channel burst requests (packed, channel i at slice i)
//   ch_wr_burst_data_req/finish       : controller handshakes routed to the granted channel only
//   wr_burst_req/len/addr/data        : request to the controller (len/addr held from grant to finish)
//   wr_burst_data_req/finish          : handshakes from the controller
//   grant                             : one-hot owner, zero when idle
//   Build option MEM_BURST_ARBITER_PRIO_CH0_EN: channel 0 always wins in IDLE and does not move rr_ptr.
module mem_burst_arbiter
    import mem_burst_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_wr_burst_req,
    input  logic [NUM_CH*LEN_W-1:0]  ch_wr_burst_len,
    input  logic [NUM_CH*ADDR_W-1:0] ch_wr_burst_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wr_burst_data,
    output logic [NUM_CH-1:0]        ch_wr_burst_data_req,
    output logic [NUM_CH-1:0]        ch_wr_burst_finish,
    output logic                     wr_burst_req,
    output logic [LEN_W-1:0]         wr_burst_len,
    output logic [ADDR_W-1:0]        wr_burst_addr,
    output logic [DATA_W-1:0]        wr_burst_data,
    input  logic                     wr_burst_data_req,
    input  logic                     wr_burst_finish,
    output logic [NUM_CH-1:0]        grant
);
    localparam int PW = $clog2(NUM_CH);
`ifdef MEM_BURST_ARBITER_PRIO_CH0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    state_t            state, state_n;
    logic [NUM_CH-1:0] grant_n, rr_win, win;
    logic [PW-1:0]     rr_ptr, ptr_n, gidx, inc;
    logic              req_n;
    logic [LEN_W-1:0]  len_n, win_len;
    logic [ADDR_W-1:0] addr_n, win_addr;
    logic              active;

    rr_pick #(.N(NUM_CH), .PW(PW)) u_pick (
        .req    (ch_wr_burst_req),
        .rr_ptr (rr_ptr),
        .win    (rr_win)
    );

    assign win    = PRIO && ch_wr_burst_req[0] ? NUM_CH'(1) : rr_win;
    assign gidx   = PW'(oh_idx(8'(grant)));
    assign inc    = PW'((int'(gidx) + 1) % NUM_CH);
    assign active = state != IDLE;

    assign ch_wr_burst_data_req = active && wr_burst_data_req ? grant : '0;
    assign ch_wr_burst_finish   = active && wr_burst_finish ? grant : '0;

    always_comb begin
        win_len       = '0;
        win_addr      = '0;
        wr_burst_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win[i]) win_len = ch_wr_burst_len[i*LEN_W +: LEN_W];
            if (win[i]) win_addr = ch_wr_burst_addr[i*ADDR_W +: ADDR_W];
            if (grant[i]) wr_burst_data = ch_wr_burst_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        req_n   = wr_burst_req;
        len_n   = wr_burst_len;
        addr_n  = wr_burst_addr;
        ptr_n   = rr_ptr;
        case (state)
            IDLE: if (|ch_wr_burst_req) begin
                state_n = GRANT;
                grant_n = win;
                req_n   = 1'b1;
                len_n   = win_len;
                addr_n  = win_addr;
            end
            default: if (wr_burst_finish) begin
                state_n = IDLE;
                grant_n = '0;
                req_n   = 1'b0;
                // A priority win of channel 0 leaves the rotation untouched.
                ptr_n   = PRIO && grant[0] ? rr_ptr : inc;
            end else if (wr_burst_data_req) begin
                state_n = WAIT;
            end
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            wr_burst_req  <= 1'b0;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            rr_ptr        <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            wr_burst_req  <= req_n;
            wr_burst_len  <= len_n;
            wr_burst_addr <= addr_n;
            rr_ptr        <= ptr_n;
        end
    end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: directed self-checking bench for mem_burst_arbiter (4 channels, default widths).
module tb_mem_burst_arbiter;
    localparam int N = 4;
    localparam int DW = 64;
    localparam int AW = 24;
    localparam int LW = 10;

    logic            mem_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    ch_wr_burst_req;
    logic [N*LW-1:0] ch_wr_burst_len;
    logic [N*AW-1:0] ch_wr_burst_addr;
    logic [N*DW-1:0] ch_wr_burst_data;
    logic [N-1:0]    ch_wr_burst_data_req;
    logic [N-1:0]    ch_wr_burst_finish;
    logic            wr_burst_req;
    logic [LW-1:0]   wr_burst_len;
    logic [AW-1:0]   wr_burst_addr;
    logic [DW-1:0]   wr_burst_data;
    logic            wr_burst_data_req;
    logic            wr_burst_finish;
    logic [N-1:0]    grant;

    logic [LW-1:0] cfg_len [N];
    logic [AW-1:0] cfg_addr[N];
    logic [DW-1:0] cfg_data[N];
    int total = 0;
    int bad = 0;

    always #5 mem_clk = ~mem_clk;

    mem_burst_arbiter dut (
        .mem_clk              (mem_clk),
        .rst_n                (rst_n),
        .ch_wr_burst_req      (ch_wr_burst_req),
        .ch_wr_burst_len      (ch_wr_burst_len),
        .ch_wr_burst_addr     (ch_wr_burst_addr),
        .ch_wr_burst_data     (ch_wr_burst_data),
        .ch_wr_burst_data_req (ch_wr_burst_data_req),
        .ch_wr_burst_finish   (ch_wr_burst_finish),
        .wr_burst_req         (wr_burst_req),
        .wr_burst_len         (wr_burst_len),
        .wr_burst_addr        (wr_burst_addr),
        .wr_burst_data        (wr_burst_data),
        .wr_burst_data_req    (wr_burst_data_req),
        .wr_burst_finish      (wr_burst_finish),
        .grant                (grant)
    );

    always_comb begin
        ch_wr_burst_len  = '0;
        ch_wr_burst_addr = '0;
        ch_wr_burst_data = '0;
        for (int i = 0; i < N; i++) begin
            ch_wr_burst_len[i*LW +: LW]  = cfg_len[i];
            ch_wr_burst_addr[i*AW +: AW] = cfg_addr[i];
            ch_wr_burst_data[i*DW +: DW] = cfg_data[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Entered one step after the grant edge; leaves one step after the idle-gap edge.
    task automatic run_burst(input int ch, input int n);
        logic [N-1:0] oh;
        oh = N'(1) << ch;
        chk("grant", grant, oh);
        chk("req_hi", wr_burst_req, 1);
        chk("len", wr_burst_len, cfg_len[ch]);
        chk("addr", wr_burst_addr, cfg_addr[ch]);
        for (int i = 0; i < n; i++) begin
            wr_burst_data_req = 1'b1;
            #1;
            chk("ch_data_req", ch_wr_burst_data_req, oh);
            chk("data_mux", wr_burst_data, cfg_data[ch]);
            tick();
        end
        wr_burst_data_req = 1'b0;
        wr_burst_finish = 1'b1;
        #1;
        chk("ch_finish", ch_wr_burst_finish, oh);
        chk("req_until_fin", wr_burst_req, 1);
        chk("len_held", wr_burst_len, cfg_len[ch]);
        tick();
        wr_burst_finish = 1'b0;
        #1;
        chk("grant_clr", grant, 0);
        chk("req_clr", wr_burst_req, 0);
        chk("finish_once", ch_wr_burst_finish, 0);
    endtask

    initial begin
        int first;
        int second;
        cfg_len  = '{10'd3, 10'd7, 10'd16, 10'd11};
        cfg_addr = '{24'h000100, 24'h00A000, 24'h001000, 24'hFFFF00};
        cfg_data = '{64'hD0D0_0000_0000_0000, 64'hD1D1_1111_0000_0001,
                     64'hD2D2_2222_0000_0002, 64'hD3D3_3333_0000_0003};
        ch_wr_burst_req   = '0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        do_reset();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_req", wr_burst_req, 0);
        chk("rst_len", wr_burst_len, 0);
        chk("rst_addr", wr_burst_addr, 0);
        chk("rst_ptr", dut.rr_ptr, 0);

        // Single channel 2, len 16, addr 0x001000.
        ch_wr_burst_req = 4'b0100;
        #1;
        chk("pre_grant", grant, 0);
        tick();
        ch_wr_burst_req = '0;
        run_burst(2, 16);

        // All channels requesting: 0,1,2,3,0 with one idle cycle between.
        do_reset();
        ch_wr_burst_req = 4'b1111;
        tick();
        run_burst(0, 1);
        chk("gap", grant, 0);
        tick();
        run_burst(1, 2);
        tick();
        run_burst(2, 1);
        tick();
        run_burst(3, 1);
        tick();
        run_burst(0, 1);
        ch_wr_burst_req = '0;

        // Ch1 drops request right after grant (rr_ptr=1).
        ch_wr_burst_req = 4'b0010;
        tick();
        ch_wr_burst_req = '0;
        run_burst(1, 3);

        // Zero-length burst: finish arrives in GRANT (rr_ptr=2).
        cfg_len[3] = 10'd0;
        ch_wr_burst_req = 4'b1000;
        tick();
        ch_wr_burst_req = '0;
        run_burst(3, 0);
        tick();
        chk("stay_idle", grant, 0);

        // Controller strobes while idle are ignored.
        wr_burst_data_req = 1'b1;
        wr_burst_finish = 1'b1;
        #1;
        chk("idle_data_req", ch_wr_burst_data_req, 0);
        chk("idle_finish", ch_wr_burst_finish, 0);
        tick();
        chk("idle_no_grant", grant, 0);
        wr_burst_data_req = 1'b0;
        wr_burst_finish = 1'b0;

        // Reset during WAIT of ch3 (rr_ptr=2 while ch3 owns the bus).
        ch_wr_burst_req = 4'b0010;
        tick();
        ch_wr_burst_req = '0;
        run_burst(1, 1);
        ch_wr_burst_req = 4'b1000;
        tick();
        chk("ch3_grant", grant, 4'b1000);
        ch_wr_burst_req = '0;
        wr_burst_data_req = 1'b1;
        tick();
        chk("ch3_wait", ch_wr_burst_data_req, 4'b1000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_grant", grant, 0);
        chk("abort_req", wr_burst_req, 0);
        chk("abort_ptr", dut.rr_ptr, 0);
        chk("abort_finish", ch_wr_burst_finish, 0);
        chk("abort_data_req", ch_wr_burst_data_req, 0);
        wr_burst_data_req = 1'b0;
        ch_wr_burst_req = 4'b1111;
        tick();
        chk("post_rst_rr", grant, 4'b0001);
        ch_wr_burst_req = '0;
        run_burst(0, 1);

        // Ch0 and ch2 requesting with rr_ptr=2 (ch1 burst moves ptr to 2).
        ch_wr_burst_req = 4'b0010;
        tick();
        ch_wr_burst_req = '0;
        run_burst(1, 1);
        chk("ptr_two", dut.rr_ptr, 2);
`ifdef MEM_BURST_ARBITER_PRIO_CH0_EN
        first = 0;
        second = 2;
`else
        first = 2;
        second = 0;
`endif
        ch_wr_burst_req = 4'b0101;
        tick();
        ch_wr_burst_req = 4'b0101 & ~(4'b0001 << first);
        run_burst(first, 1);
        tick();
        ch_wr_burst_req = '0;
        run_burst(second, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
